// File: rtl/io_sevenseg_scan_if.sv
// Bus bundle between the I/O output registers and the seven-segment scanner.
//   in_port0   : out_port0 value, [15:0] shown on digits 3..0
//   in_port1   : out_port1 value, [15:0] shown on digits 7..4, [23:16] dp mask
//   disp_en    : 1 = scan, 0 = freeze counters and blank all digits
//   an_n       : digit anodes, active-low
//   seg_n      : segments {g,f,e,d,c,b,a}, active-low
//   dp_n       : decimal point, active-low
//   frame_done : one-cycle pulse when the frame snapshot reloads
// master drives the port values, slave is the scanner.
interface io_sevenseg_scan_if;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic        disp_en;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output in_port0,
        output in_port1,
        output disp_en,
        input  an_n,
        input  seg_n,
        input  dp_n,
        input  frame_done
    );

    modport slave (
        input  in_port0,
        input  in_port1,
        input  disp_en,
        output an_n,
        output seg_n,
        output dp_n,
        output frame_done
    );
endinterface

// File: rtl/io_sevenseg_scan.sv
// Time-multiplexed 8-digit seven-segment driver.
// Shows {in_port1[15:0], in_port0[15:0]} as 8 hex digits, one digit per slot of DIV
// clocks, with the first BLANK_CYC clocks of each slot dark to suppress ghosting.
// The ports are snapshotted once per frame (and on the first enabled edge after
// reset) so a digit never changes mid-scan.
// Ports:
//   clock : system clock, rising edge
//   clrn  : asynchronous active-low reset
//   bus   : io_sevenseg_scan_if.slave (port values, disp_en, an_n/seg_n/dp_n, frame_done)
// Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking per 4-digit half
// (digits 0 and 4 always shown; blanked digits also force dp_n high).
module io_sevenseg_scan #(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic                clock,
    input  logic                clrn,
    io_sevenseg_scan_if.slave   bus
);

    localparam int unsigned PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PCW-1:0] PC_LAST  = PCW'(DIV - 1);
    localparam logic [PCW-1:0] PC_BLANK = PCW'(BLANK_CYC);

    // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEVENSEG_LZB_EN
    // 1 when digit i and every higher digit of its half are zero, and i is not
    // the half's lowest digit.
    function automatic logic lz_blank(input logic [31:0] s, input logic [2:0] i);
        logic       blank;
        logic [4:0] lsb;
        blank = (i[1:0] != 2'd0);
        for (int j = 0; j < 4; j++) begin
            lsb = {i[2], 2'(j), 2'b00};
            if ((2'(j) >= i[1:0]) && (s[lsb +: 4] != 4'h0)) begin
                blank = 1'b0;
            end
        end
        return blank;
    endfunction
`endif

    // Scan state
    logic [PCW-1:0] pcnt;
    logic [2:0]     idx;
    logic [31:0]    snap;
    logic [7:0]     dpm;
    logic           first;

    // Next-state and next-output values
    logic [PCW-1:0] pcnt_nx;
    logic [2:0]     idx_nx;
    logic [31:0]    snap_nx;
    logic [7:0]     dpm_nx;
    logic           first_nx;
    logic           fd_nx;
    logic [7:0]     an_nx;
    logic [6:0]     seg_nx;
    logic           dp_nx;

    logic           slot_end;
    logic           reload;
    logic           lz;
    logic [4:0]     nib_lsb;
    logic [3:0]     nib;

    // Port bits that never reach the display.
    logic unused_bits;
    assign unused_bits = ^{bus.in_port0[31:16], bus.in_port1[31:24]};

    // Next-state / next-output logic; outputs follow the updated pcnt/idx/snapshot.
    always_comb begin
        pcnt_nx  = pcnt;
        idx_nx   = idx;
        snap_nx  = snap;
        dpm_nx   = dpm;
        first_nx = first;
        fd_nx    = 1'b0;
        an_nx    = 8'hFF;
        seg_nx   = 7'h7F;
        dp_nx    = 1'b1;
        lz       = 1'b0;
        nib_lsb  = 5'd0;
        nib      = 4'h0;

        slot_end = (pcnt == PC_LAST);
        reload   = first || (slot_end && (idx == 3'd7));

        if (bus.disp_en) begin
            pcnt_nx = slot_end ? '0 : pcnt + PCW'(1);
            idx_nx  = slot_end ? idx + 3'd1 : idx;

            // Snapshot only at frame wrap (or the first enabled edge) so a frame is coherent.
            if (reload) begin
                snap_nx  = {bus.in_port1[15:0], bus.in_port0[15:0]};
                dpm_nx   = bus.in_port1[23:16];
                first_nx = 1'b0;
                fd_nx    = 1'b1;
            end

            nib_lsb = {idx_nx, 2'b00};
            nib     = snap_nx[nib_lsb +: 4];

`ifdef SEVENSEG_LZB_EN
            lz = lz_blank(snap_nx, idx_nx);
`else
            lz = 1'b0;
`endif

            if ((pcnt_nx >= PC_BLANK) && !lz) begin
                an_nx  = ~(8'd1 << idx_nx);
                seg_nx = hex_seg(nib);
                dp_nx  = ~dpm_nx[idx_nx];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            pcnt           <= '0;
            idx            <= 3'd0;
            snap           <= 32'h0;
            dpm            <= 8'h0;
            first          <= 1'b1;
            bus.an_n       <= 8'hFF;
            bus.seg_n      <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            pcnt           <= pcnt_nx;
            idx            <= idx_nx;
            snap           <= snap_nx;
            dpm            <= dpm_nx;
            first          <= first_nx;
            bus.an_n       <= an_nx;
            bus.seg_n      <= seg_nx;
            bus.dp_n       <= dp_nx;
            bus.frame_done <= fd_nx;
        end
    end

endmodule

// File: tb/tb_io_sevenseg_scan.sv
// Self-checking bench for io_sevenseg_scan (DIV=8, BLANK_CYC=2): a fixed-vector
// table for the static scan, hand sequences for the frame-level corner cases, and
// a randomized run checked every cycle against a position-based reference model.
module tb_io_sevenseg_scan;

    localparam int unsigned DIV       = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = 8 * DIV;

    logic clock = 1'b0;
    logic clrn  = 1'b0;

    io_sevenseg_scan_if bus();

    io_sevenseg_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: pos counts enabled edges since reset; slot/digit derive from it.
    int          pos;
    bit          m_first;
    logic [31:0] m_snap;
    logic [7:0]  m_dpm;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    bit          seg_known;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos       = 0;
        m_first   = 1'b1;
        m_snap    = 32'h0;
        m_dpm     = 8'h0;
        e_an      = 8'hFF;
        e_seg     = 7'h7F;
        e_dp      = 1'b1;
        e_fd      = 1'b0;
        seg_known = 1'b1;
    endtask

    task automatic model_edge();
        int          pc;
        int          ix;
        logic [31:0] half;
        logic [3:0]  nib;
        bit          blank;
        if (!clrn) begin
            model_reset();
        end else if (!bus.disp_en) begin
            e_fd      = 1'b0;
            e_an      = 8'hFF;
            seg_known = 1'b0;
        end else begin
            e_fd = 1'b0;
            if (m_first || (pos % FRAME == FRAME - 1)) begin
                m_snap  = {bus.in_port1[15:0], bus.in_port0[15:0]};
                m_dpm   = bus.in_port1[23:16];
                m_first = 1'b0;
                e_fd    = 1'b1;
            end
            pos++;
            pc        = pos % DIV;
            ix        = (pos / DIV) % 8;
            seg_known = 1'b1;
            nib       = 4'((m_snap >> (4 * ix)) & 32'hF);
            blank     = (pc < BLANK_CYC);
`ifdef SEVENSEG_LZB_EN
            half = (m_snap >> (16 * (ix / 4))) & 32'hFFFF;
            if ((ix % 4 != 0) && ((half >> (4 * (ix % 4))) == 0)) blank = 1'b1;
`else
            half = 32'h0;
`endif
            if (blank) begin
                e_an  = 8'hFF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = 8'hFF ^ (8'd1 << ix);
                e_seg = hex_tab[nib];
                e_dp  = ~m_dpm[ix];
            end
        end
    endtask

    task automatic compare_model();
        chk("model an_n", 32'(bus.an_n), 32'(e_an));
        chk("model frame_done", 32'(bus.frame_done), 32'(e_fd));
        if (seg_known) begin
            chk("model seg_n", 32'(bus.seg_n), 32'(e_seg));
            chk("model dp_n", 32'(bus.dp_n), 32'(e_dp));
        end
    endtask

    // One clock: update the model at the edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clock);
        model_edge();
        edge_n++;
        @(negedge clock);
        compare_model();
    endtask

    task automatic chk_out(input string name, input logic [7:0] an, input logic [6:0] seg,
                           input logic dp, input logic fd);
        chk({name, " an_n"}, 32'(bus.an_n), 32'(an));
        chk({name, " seg_n"}, 32'(bus.seg_n), 32'(seg));
        chk({name, " dp_n"}, 32'(bus.dp_n), 32'(dp));
        chk({name, " frame_done"}, 32'(bus.frame_done), 32'(fd));
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w[4*i +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        return w;
    endfunction

    typedef struct {
        int          edge_no;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t tab[$];

    initial begin
        logic [7:0] lit;

        // Static-scan vectors: edge number after reset release and the expected outputs.
        tab.push_back('{1,  32'h3210, 32'h7654, 8'hFF, 7'h7F, 1'b1, 1'b1});
        tab.push_back('{2,  32'h3210, 32'h7654, 8'hFE, 7'h40, 1'b1, 1'b0});
        tab.push_back('{9,  32'h3210, 32'h7654, 8'hFF, 7'h7F, 1'b1, 1'b0});
        tab.push_back('{10, 32'h3210, 32'h7654, 8'hFD, 7'h79, 1'b1, 1'b0});
        tab.push_back('{18, 32'h3210, 32'h7654, 8'hFB, 7'h24, 1'b1, 1'b0});
        tab.push_back('{26, 32'h3210, 32'h7654, 8'hF7, 7'h30, 1'b1, 1'b0});
        tab.push_back('{34, 32'h3210, 32'h7654, 8'hEF, 7'h19, 1'b1, 1'b0});
        tab.push_back('{42, 32'h3210, 32'h7654, 8'hDF, 7'h12, 1'b1, 1'b0});
        tab.push_back('{50, 32'h3210, 32'h7654, 8'hBF, 7'h02, 1'b1, 1'b0});
        tab.push_back('{58, 32'h3210, 32'h7654, 8'h7F, 7'h78, 1'b1, 1'b0});
        tab.push_back('{63, 32'h3210, 32'h7654, 8'h7F, 7'h78, 1'b1, 1'b0});
        tab.push_back('{64, 32'h3210, 32'h7654, 8'hFF, 7'h7F, 1'b1, 1'b1});

        // Reset held with the clock running.
        bus.in_port0 = 32'h0000_3210;
        bus.in_port1 = 32'h0000_7654;
        bus.disp_en  = 1'b1;
        clrn         = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk_out("reset", 8'hFF, 7'h7F, 1'b1, 1'b0);

        // Static scan driven from the vector table.
        clrn   = 1'b1;
        edge_n = 0;
        for (int k = 0; k < tab.size(); k++) begin
            bus.in_port0 = tab[k].p0;
            bus.in_port1 = tab[k].p1;
            while (edge_n < tab[k].edge_no) cyc();
            chk_out($sformatf("scan edge %0d", tab[k].edge_no),
                    tab[k].an, tab[k].seg, tab[k].dp, tab[k].fd);
        end

        // Tear-free: port0 changes while digit 2 is in its slot.
        while (edge_n < 83) cyc();
        bus.in_port0 = 32'h0000_FFFF;
        while (edge_n < 90) cyc();
        chk_out("tear old digit3", 8'hF7, 7'h30, 1'b1, 1'b0);
        while (edge_n < 127) cyc();
        chk("tear pre-wrap frame_done", 32'(bus.frame_done), 32'h0);
        cyc();
        chk("tear wrap frame_done", 32'(bus.frame_done), 32'h1);
        while (edge_n < 130) cyc();
        chk_out("tear new digit0", 8'hFE, 7'h0E, 1'b1, 1'b0);

        // DP mask 0x05: visible only from the next frame, only on lit digits 0 and 2.
        bus.in_port1 = 32'h0005_7654;
        while (edge_n < 192) cyc();
        chk("dp during blank", 32'(bus.dp_n), 32'h1);
        while (edge_n < 194) cyc();
        chk("dp digit0", 32'(bus.dp_n), 32'h0);
        while (edge_n < 202) cyc();
        chk("dp digit1", 32'(bus.dp_n), 32'h1);
        while (edge_n < 208) cyc();
        chk("dp digit2 blank", 32'(bus.dp_n), 32'h1);
        while (edge_n < 210) cyc();
        chk("dp digit2", 32'(bus.dp_n), 32'h0);

        // disp_en dropped at idx=3, pcnt=5 for 20 clocks, then re-raised.
        while (edge_n < 221) cyc();
        chk("en before drop an_n", 32'(bus.an_n), 32'hF7);
        bus.disp_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("en low an_n", 32'(bus.an_n), 32'hFF);
        end
        bus.disp_en = 1'b1;
        cyc();
        chk("en resume an_n", 32'(bus.an_n), 32'hF7);
        cyc();
        chk("en resume end-of-slot an_n", 32'(bus.an_n), 32'hF7);
        cyc();
        chk("en resume next slot blank", 32'(bus.an_n), 32'hFF);

        // Reset asserted mid-slot takes effect without a clock edge.
        repeat (4) cyc();
        #2;
        clrn = 1'b0;
        #1;
        chk_out("async reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
        model_reset();
        repeat (2) cyc();

        // Leading zeros: which digits light over one full frame.
        bus.in_port0 = 32'h0000_0005;
        bus.in_port1 = 32'h0000_0000;
        clrn = 1'b1;
        lit  = 8'h00;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            lit = lit | ~bus.an_n;
        end
`ifdef SEVENSEG_LZB_EN
        chk("lzb lit digits", 32'(lit), 32'h11);
`else
        chk("lzb lit digits", 32'(lit), 32'hFF);
`endif

        // Randomized ports, enable gaps and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.in_port0 = rnd_word();
                bus.in_port1 = {8'($urandom), 8'($urandom), 16'(rnd_word())};
            end
            bus.disp_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                clrn = 1'b0;
                model_reset();
                cyc();
                clrn = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
